instr_mem_loadable: RTL and testbench
=====================================

# instr_mem_loadable

Parametrised, loadable successor to the CPU's instruction memory. A byte-serial load port with a valid/ready handshake fills the array at run time, replacing the hard-coded program. A registered fetch port returns big-endian instruction words one cycle after the request. The block sits between the boot/UART loader and the IF stage. The IF stage treats `fetch_valid` low as a fetch stall.

## Interface
- `WORD_LEN`, 32: instruction and address width in bits.
- `MEM_CELL_SIZE`, 8: bits per memory cell, which is also the load byte width.
- `INSTR_MEM_SIZE`, 1024: number of cells. Must be a power of two and a multiple of `BPW`.
- `BPW`, derived as `WORD_LEN/MEM_CELL_SIZE`: cells per word. Not overridable.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `load_start`  in  1  begin a load at cell 0. Honoured only in IDLE.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  `MEM_CELL_SIZE`  byte to write.
- `load_last`  in  1  marks the final byte of the image. Qualified by `load_valid`.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `load_count`  out  `$clog2(INSTR_MEM_SIZE)+1`  bytes written by the current or last load.
- `fetch_en`  in  1  fetch request.
- `fetch_addr`  in  `WORD_LEN`  byte address of the first cell.
- `fetch_valid`  out  1  `instruction` is valid this cycle.
- `instruction`  out  `WORD_LEN`  fetched word.
- `fetch_misaligned`  out  1  the fetch that produced `instruction` had `fetch_addr % BPW != 0`.

## Operation
- Loader FSM states:
  - IDLE to LOAD on `load_start`. The pointer and `load_count` clear to 0.
  - LOAD to DONE when a byte is accepted with `load_last`=1, or when the pointer is at `INSTR_MEM_SIZE-1`. Reaching the last cell ends the load even without `load_last`, and there is no wrap during a load.
  - DONE to IDLE unconditionally after one cycle.
- `load_ready` is 1 only in LOAD. A byte is accepted on `load_valid && load_ready`:
  - the byte is written to `mem[ptr]`;
  - the pointer increments;
  - `load_count` increments.
- `load_start` is ignored outside IDLE. `load_valid` and `load_last` are ignored outside LOAD.
- `load_done`=1 exactly in DONE.
- Fetch is serviced only when the FSM is in IDLE or DONE. In LOAD, requests are dropped and `fetch_valid`=0.
- Fetch address handling:
  - `a = fetch_addr[$clog2(INSTR_MEM_SIZE)-1:0]`. Upper address bits are ignored, so addresses alias.
  - The word is `{mem[a], mem[a+1], …, mem[a+BPW-1]}`, with each index computed modulo `INSTR_MEM_SIZE`. Wrap-around at the top is required.
- Misaligned fetches still return the assembled word. `fetch_misaligned` flags them; the block takes no other action.
- When no fetch is accepted:
  - `instruction` holds its last value;
  - `fetch_valid` and `fetch_misaligned` are 0.
- Same-cycle `load_start` and `fetch_en` in IDLE: the fetch is accepted and returned next cycle. LOAD begins on the same edge.
- Memory cells are not reset and are undefined until loaded. Reset does not clear cells already written.

## Timing
- Reset values:
  - state IDLE, pointer 0;
  - `load_ready`=0, `load_done`=0, `load_count`=0;
  - `fetch_valid`=0, `instruction`=0, `fetch_misaligned`=0.
- Fetch latency is 1 cycle. A request at edge N gives `fetch_valid`, `instruction` and `fetch_misaligned` after edge N+1, for one cycle per request. Back-to-back requests give a throughput of 1 word per cycle.
- Load throughput is 1 byte per cycle while `load_valid` is held.
- `load_done` rises on the cycle after the final byte's accepting edge. The first fetch after the load can be issued in that DONE cycle.
- `rst` asserted mid-load aborts the load immediately:
  - `load_ready` drops asynchronously;
  - no `load_done` pulse is produced;
  - bytes already written are retained.

## Structure
- `defines.v` provides the defaults `WORD_LEN`, `MEM_CELL_SIZE`, `INSTR_MEM_SIZE`. FSM state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) go in the shared defines as well.
- Sub-module `instr_mem_load_fsm` contains the FSM, the pointer, `load_count`, `load_ready` and `load_done`. It outputs the write-enable and write-address to the top.
- The top level holds the cell array, the modulo-wrapped read-index generation and the fetch output registers.

## Test plan
- Load bytes 80 20 00 06 80 40 00 01 with `load_last` on byte 8, then fetch addresses 0 and 4:
  - `load_done` pulses one cycle after the last accept, `load_count`=8;
  - fetch returns 0x80200006, then 0x80400001, with `fetch_valid` high for one cycle each.
- Fetch addr 2 with the image above -> 0x00068040, `fetch_misaligned`=1.
- `INSTR_MEM_SIZE`=16, load bytes 0x00–0x0F without `load_last`:
  - auto-DONE after the 16th byte, `load_ready` drops, `load_count`=16;
  - fetch addr 14 -> 0x0E0F0001 with misaligned=1;
  - fetch addr 0x10 -> 0x00010203.
- `fetch_en` held high throughout a load -> `fetch_valid`=0 during LOAD. Valid resumes one cycle after the first request issued in DONE.
- Assert `rst` after 3 accepted bytes:
  - `load_ready`, `load_count` and `load_done` go to 0, state IDLE, no `load_done` pulse;
  - a fetch of addr 0 returns the 3 written bytes as the top three bytes of `instruction`.
- `load_start` pulsed during LOAD -> ignored: the pointer keeps counting and `load_count` is not cleared.

Source files
------------

// File: rtl/instr_mem_loadable_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable_pkg
// Shared defaults and loader FSM state encoding for the loadable instruction
// memory. Imported by instr_mem_load_fsm and instr_mem_loadable.
//   WORD_LEN_DEF       : default instruction / address width in bits
//   MEM_CELL_SIZE_DEF  : default bits per cell (also the load byte width)
//   INSTR_MEM_SIZE_DEF : default number of cells
//   load_state_e       : IDLE=0, LOAD=1, DONE=2
// -----------------------------------------------------------------------------
package instr_mem_loadable_pkg;

  localparam int unsigned WORD_LEN_DEF       = 32;
  localparam int unsigned MEM_CELL_SIZE_DEF  = 8;
  localparam int unsigned INSTR_MEM_SIZE_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_mem_loadable_load_fsm.sv
// -----------------------------------------------------------------------------
// instr_mem_load_fsm
// Byte-serial loader control: state machine, write pointer, byte counter and
// the load-port handshake outputs.
//
// Handshake: a byte is accepted on a rising edge where load_valid && load_ready.
// load_ready is a pure decode of the state register (high only in LOAD), so it
// never depends combinationally on load_valid and drops as soon as reset hits.
//
// Ports
//   clk, rst      : clock, asynchronous active-low reset
//   load_start    : begin a load at cell 0 (IDLE only)
//   load_valid    : byte offered this cycle
//   load_last     : offered byte is the final one of the image
//   load_ready    : byte can be accepted this cycle
//   load_done     : one-cycle pulse (DONE state)
//   load_count    : bytes written by the current / last load
//   we_o, waddr_o : cell write enable and address for the array
//   state_o       : current FSM state (also used by the top to gate fetches)
// -----------------------------------------------------------------------------
module instr_mem_load_fsm
  import instr_mem_loadable_pkg::*;
#(
  parameter  int unsigned DEPTH = INSTR_MEM_SIZE_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_last,
  output logic             load_ready,
  output logic             load_done,
  output logic [CNT_W-1:0] load_count,
  output logic             we_o,
  output logic [PTR_W-1:0] waddr_o,
  output load_state_e      state_o
);

  load_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = load_valid && (state_q == ST_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          // Writing the top cell ends the load: the pointer must never wrap
          // back over cell 0 within one image.
          if (load_last || (ptr_q == PTR_W'(DEPTH - 1))) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_ready = (state_q == ST_LOAD);
  assign load_done  = (state_q == ST_DONE);
  assign load_count = cnt_q;
  assign we_o       = accept;
  assign waddr_o    = ptr_q;
  assign state_o    = state_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
// Run-time loadable instruction memory. A byte-serial load port fills the
// cell array; a registered fetch port returns big-endian words one cycle after
// the request.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   load_start        : begin a load at cell 0 (IDLE only)
//   load_valid/ready  : byte handshake, accepted when both are high at an edge
//   load_data         : byte to write
//   load_last         : final byte of the image
//   load_done         : one-cycle pulse after the final byte is accepted
//   load_count        : bytes written by the current / last load
//   fetch_en          : fetch request (dropped while a load is in progress)
//   fetch_addr        : byte address of the first cell of the word
//   fetch_valid       : instruction valid this cycle
//   instruction       : fetched word, holds its value between fetches
//   fetch_misaligned  : the returning fetch had an address not word-aligned
// -----------------------------------------------------------------------------
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter  int unsigned WORD_LEN       = WORD_LEN_DEF,
  parameter  int unsigned MEM_CELL_SIZE  = MEM_CELL_SIZE_DEF,
  parameter  int unsigned INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEF,
  localparam int unsigned BPW            = WORD_LEN / MEM_CELL_SIZE,
  localparam int unsigned A_W            = $clog2(INSTR_MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [MEM_CELL_SIZE-1:0] load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [A_W:0]             load_count,
  input  logic                     fetch_en,
  input  logic [WORD_LEN-1:0]      fetch_addr,
  output logic                     fetch_valid,
  output logic [WORD_LEN-1:0]      instruction,
  output logic                     fetch_misaligned
);

  logic [MEM_CELL_SIZE-1:0] mem_q [INSTR_MEM_SIZE];

  logic          we;
  logic [A_W-1:0] waddr;
  load_state_e   fsm_state;

  instr_mem_load_fsm #(
    .DEPTH (INSTR_MEM_SIZE)
  ) u_load_fsm (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .we_o       (we),
    .waddr_o    (waddr),
    .state_o    (fsm_state)
  );

  // Cells are deliberately not reset: an aborted load keeps what it wrote.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= load_data;
    end
  end

  // Upper address bits are dropped so addresses alias; A_W-bit addition makes
  // the per-byte index wrap modulo the array size.
  logic [A_W-1:0]      base_addr;
  wire  [WORD_LEN-1:0] rd_word;

  assign base_addr = fetch_addr[A_W-1:0];

  for (genvar g = 0; g < BPW; g++) begin : g_rd
    logic [A_W-1:0] idx;
    assign idx = base_addr + A_W'(g);
    // Cell at the lowest address lands in the most significant byte.
    assign rd_word[WORD_LEN-1-g*MEM_CELL_SIZE -: MEM_CELL_SIZE] = mem_q[idx];
  end

  logic fetch_ok;
  logic misaligned;

  assign fetch_ok   = fetch_en && (fsm_state != ST_LOAD);
  assign misaligned = (fetch_addr % WORD_LEN'(BPW)) != '0;

  logic                fetch_valid_q;
  logic [WORD_LEN-1:0] instr_q;
  logic                misaligned_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_valid_q <= 1'b0;
      instr_q       <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_ok;
      misaligned_q  <= fetch_ok && misaligned;
      if (fetch_ok) begin
        instr_q <= rd_word;
      end
    end
  end

  assign fetch_valid      = fetch_valid_q;
  assign instruction      = instr_q;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        sel; // 0: 1024-cell DUT, 1: 16-cell DUT

  always #5 clk = ~clk;

  // Per-DUT inputs: the unselected DUT sees an idle port.
  logic        b_ls, b_lv, b_ll, b_fe, s_ls, s_lv, s_ll, s_fe;
  logic [7:0]  b_ld, s_ld;
  logic [31:0] b_fa, s_fa;
  assign b_ls = sel ? 1'b0 : load_start;
  assign b_lv = sel ? 1'b0 : load_valid;
  assign b_ll = sel ? 1'b0 : load_last;
  assign b_fe = sel ? 1'b0 : fetch_en;
  assign b_ld = load_data;
  assign b_fa = fetch_addr;
  assign s_ls = sel ? load_start : 1'b0;
  assign s_lv = sel ? load_valid : 1'b0;
  assign s_ll = sel ? load_last  : 1'b0;
  assign s_fe = sel ? fetch_en   : 1'b0;
  assign s_ld = load_data;
  assign s_fa = fetch_addr;

  logic        b_ready, b_done, b_fv, b_mis, s_ready, s_done, s_fv, s_mis;
  logic [10:0] b_count;
  logic [4:0]  s_count;
  logic [31:0] b_instr, s_instr;

  instr_mem_loadable u_big (
    .clk (clk), .rst (rst),
    .load_start (b_ls), .load_valid (b_lv), .load_data (b_ld), .load_last (b_ll),
    .load_ready (b_ready), .load_done (b_done), .load_count (b_count),
    .fetch_en (b_fe), .fetch_addr (b_fa),
    .fetch_valid (b_fv), .instruction (b_instr), .fetch_misaligned (b_mis)
  );

  instr_mem_loadable #(.INSTR_MEM_SIZE(16)) u_small (
    .clk (clk), .rst (rst),
    .load_start (s_ls), .load_valid (s_lv), .load_data (s_ld), .load_last (s_ll),
    .load_ready (s_ready), .load_done (s_done), .load_count (s_count),
    .fetch_en (s_fe), .fetch_addr (s_fa),
    .fetch_valid (s_fv), .instruction (s_instr), .fetch_misaligned (s_mis)
  );

  logic        o_ready, o_done, o_fv, o_mis;
  logic [10:0] o_count;
  logic [31:0] o_instr;
  assign o_ready = sel ? s_ready : b_ready;
  assign o_done  = sel ? s_done  : b_done;
  assign o_fv    = sel ? s_fv    : b_fv;
  assign o_mis   = sel ? s_mis   : b_mis;
  assign o_count = sel ? {6'b0, s_count} : b_count;
  assign o_instr = sel ? s_instr : b_instr;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] img [16];

  // Start a load and stream img[0..n-1]; returns in the cycle after the last
  // accepting edge.
  task automatic load_seq(input int n, input bit with_last);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = with_last && (i == n - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_mis;
  } fetch_vec_t;

  fetch_vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h8020_0006, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h8040_0001, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'h0006_8040, 1'b1};
    vecs[3] = '{32'h0000_0001, 32'h2000_0680, 1'b1};
    vecs[4] = '{32'h0000_0003, 32'h0680_4000, 1'b1};
    vecs[5] = '{32'h0000_0400, 32'h8020_0006, 1'b0};
    vecs[6] = '{32'hFFFF_F404, 32'h8040_0001, 1'b0};

    rst = 1'b0; sel = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    fetch_en = 1'b0; fetch_addr = 32'h0;
    step(); step();

    // Reset values
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_count", {21'b0, o_count}, 32'd0);
    chk("rst_fv", {31'b0, o_fv}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_mis", {31'b0, o_mis}, 32'd0);
    rst = 1'b1;
    step();

    // Main image load with load_last on byte 8
    img[0] = 8'h80; img[1] = 8'h20; img[2] = 8'h00; img[3] = 8'h06;
    img[4] = 8'h80; img[5] = 8'h40; img[6] = 8'h00; img[7] = 8'h01;
    load_seq(8, 1'b1);
    chk("load_done_pulse", {31'b0, o_done}, 32'd1);
    chk("load_count_8", {21'b0, o_count}, 32'd8);
    chk("load_ready_drop", {31'b0, o_ready}, 32'd0);

    // Back-to-back fetch table, first request issued in DONE
    for (int i = 0; i < 7; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = vecs[i].addr;
      step();
      chk($sformatf("vec%0d_fv", i), {31'b0, o_fv}, 32'd1);
      chk($sformatf("vec%0d_instr", i), o_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_mis", i), {31'b0, o_mis}, {31'b0, vecs[i].exp_mis});
      if (i == 0) chk("done_one_cycle", {31'b0, o_done}, 32'd0);
    end
    fetch_en = 1'b0;
    step();
    chk("idle_fv", {31'b0, o_fv}, 32'd0);
    chk("idle_instr_hold", o_instr, 32'h8040_0001);
    chk("idle_mis", {31'b0, o_mis}, 32'd0);

    // load_valid/load_last outside LOAD are ignored
    load_valid = 1'b1; load_data = 8'hFF; load_last = 1'b1;
    step(); step();
    chk("ign_ready", {31'b0, o_ready}, 32'd0);
    chk("ign_done", {31'b0, o_done}, 32'd0);
    chk("ign_count", {21'b0, o_count}, 32'd8);
    load_valid = 1'b0; load_last = 1'b0;
    fetch_en = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_en = 1'b0;
    chk("ign_instr", o_instr, 32'h8020_0006);

    // fetch_en held through a reload: accepted at the start edge, dropped in LOAD
    fetch_en = 1'b1; fetch_addr = 32'h4;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("hold_start_fv", {31'b0, o_fv}, 32'd1);
    chk("hold_start_instr", o_instr, 32'h8040_0001);
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = img[i]; load_last = (i == 7);
      step();
      chk($sformatf("hold_load%0d_fv", i), {31'b0, o_fv}, 32'd0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("hold_done", {31'b0, o_done}, 32'd1);
    step();
    chk("hold_resume_fv", {31'b0, o_fv}, 32'd1);
    chk("hold_resume_instr", o_instr, 32'h8040_0001);
    fetch_en = 1'b0;
    step();

    // 16-cell instance: auto-DONE at the top cell, wrap-around fetch
    sel = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_data = img[i];
      if (i == 15) chk("small_ready_b4_last", {31'b0, o_ready}, 32'd1);
      step();
    end
    chk("small_done", {31'b0, o_done}, 32'd1);
    chk("small_ready_drop", {31'b0, o_ready}, 32'd0);
    chk("small_count_16", {21'b0, o_count}, 32'd16);
    // load_valid stays high in DONE: must not write cell 0 again
    load_data = 8'hEE;
    fetch_en = 1'b1; fetch_addr = 32'd14;
    step();
    load_valid = 1'b0;
    chk("small_wrap_fv", {31'b0, o_fv}, 32'd1);
    chk("small_wrap_instr", o_instr, 32'h0E0F_0001);
    chk("small_wrap_mis", {31'b0, o_mis}, 32'd1);
    chk("small_idle_ready", {31'b0, o_ready}, 32'd0);
    fetch_addr = 32'h10;
    step();
    chk("small_alias_instr", o_instr, 32'h0001_0203);
    chk("small_alias_mis", {31'b0, o_mis}, 32'd0);
    fetch_en = 1'b0;
    sel = 1'b0;
    step();

    // Reset after 3 accepted bytes
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = img[i];
      step();
    end
    load_valid = 1'b0;
    chk("abort_pre_count", {21'b0, o_count}, 32'd3);
    chk("abort_pre_ready", {31'b0, o_ready}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_async_ready", {31'b0, o_ready}, 32'd0);
    chk("abort_count", {21'b0, o_count}, 32'd0);
    chk("abort_done", {31'b0, o_done}, 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort_no_done%0d", i), {31'b0, o_done}, 32'd0);
      chk($sformatf("abort_idle_ready%0d", i), {31'b0, o_ready}, 32'd0);
    end
    fetch_en = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_en = 1'b0;
    chk("abort_fetch_fv", {31'b0, o_fv}, 32'd1);
    chk("abort_fetch_instr", o_instr, 32'hAABB_CC06);

    // load_start pulsed mid-load is ignored
    img[0] = 8'h80; img[1] = 8'h20; img[2] = 8'h00; img[3] = 8'h06;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = img[i]; load_last = (i == 3);
      load_start = (i == 2);
      step();
      if (i == 2) begin
        chk("restart_ign_count", {21'b0, o_count}, 32'd3);
        chk("restart_ign_ready", {31'b0, o_ready}, 32'd1);
      end
    end
    load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0;
    chk("restart_done", {31'b0, o_done}, 32'd1);
    chk("restart_count", {21'b0, o_count}, 32'd4);
    fetch_en = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_en = 1'b0;
    chk("restart_fetch", o_instr, 32'h8020_0006);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
